fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/if_id_reg.sv | 31 +++
 rtl/fetch_unit.sv | 100 ++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
package fetch_pkg;

   localparam int unsigned XLEN = 32;

   // addi x0, x0, 0
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // S_REQ : free to issue a request
   // S_WAIT: one request outstanding, response will be used
   // S_DROP: one request outstanding, response will be thrown away
   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_DROP = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: valid/instr/pc with load, clear and hold.
module if_id_reg
   import fetch_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic            clear,
   input  logic [XLEN-1:0] load_instr,
   input  logic [XLEN-1:0] load_pc,
   output logic            valid,
   output logic [XLEN-1:0] instr,
   output logic [XLEN-1:0] pc
);

   // Load wins over clear; otherwise clear drops valid, else hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         instr <= NOP_INSTR;
         pc    <= '0;
      end else if (load) begin
         valid <= 1'b1;
         instr <= load_instr;
         pc    <= load_pc;
      end else if (clear) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, single-outstanding memory FSM, IF/ID register.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            if_valid,
   output logic [XLEN-1:0] if_instr,
   output logic [XLEN-1:0] if_pc,
   output logic [6:0]      if_opcode,
   input  logic            id_ready,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc
);

   fetch_state_t    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            ifid_load;
   logic            ifid_clear;
   logic            transfer;
   logic [XLEN-1:0] redirect_target;

   assign transfer        = if_valid && id_ready;
   assign redirect_target = redirect_pc & ~32'h3;

   // State and PC registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_REQ;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   // Next state, next PC, memory request and IF/ID register controls.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      imem_req  = 1'b0;
      ifid_load = 1'b0;
      unique case (state_q)
         S_REQ: begin
            if (redirect_valid) begin
               pc_d = redirect_target;
            end else if (!if_valid || id_ready) begin
               imem_req = !rst;
               state_d  = S_WAIT;
            end
         end
         S_WAIT: begin
            if (redirect_valid) begin
               pc_d    = redirect_target;
               state_d = imem_rvalid ? S_REQ : S_DROP;
            end else if (imem_rvalid) begin
               ifid_load = 1'b1;
               pc_d      = pc_q + 32'd4;
               state_d   = S_REQ;
            end
         end
         S_DROP: begin
            if (redirect_valid) begin
               pc_d = redirect_target;
            end
            // A redirect arriving with the dropped response still retires it,
            // otherwise the FSM would wait for a response that never comes.
            if (imem_rvalid) begin
               state_d = S_REQ;
            end
         end
         default: begin
            state_d = S_REQ;
         end
      endcase
      ifid_clear = redirect_valid || transfer;
   end

   assign imem_addr = pc_q;
   assign if_opcode = if_instr[6:0];

   if_id_reg u_if_id_reg (
      .clk        (clk),
      .rst        (rst),
      .load       (ifid_load),
      .clear      (ifid_clear),
      .load_instr (imem_rdata),
      .load_pc    (pc_q),
      .valid      (if_valid),
      .instr      (if_instr),
      .pc         (if_pc)
   );

endmodule
